st_serial_sub: RTL and testbench



---
 rtl/st_serial_sub.sv | 167 ++++++++++++++++
 tb/tb_st_serial_sub.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/st_serial_sub.sv
// -----------------------------------------------------------------------------
// st_serial_sub
//
// Bit-serial subtractor controller. A single 1-bit full-subtractor cell is
// reused for WIDTH consecutive cycles to compute a - b - bin, LSB first. The
// borrow is carried between bit steps in a flop, and the finished result is
// reported through a start/busy/done handshake.
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   rst    - synchronous reset, active-high
//   start  - operation request, only looked at while idle
//   a      - minuend, captured when start is accepted
//   b      - subtrahend, captured when start is accepted
//   bin    - borrow-in, captured when start is accepted
//   busy   - high while bit steps are being processed
//   done   - one-cycle pulse, d/bo/ov are valid from this cycle on
//   d      - registered difference
//   bo     - final borrow-out (unsigned a < b + bin)
//   ov     - signed two's-complement overflow of a - b - bin
// -----------------------------------------------------------------------------

// One-bit full subtractor: D = A - B - Bi, with borrow-out Bo.
module st_fs_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bi_i,
    output logic d_o,
    output logic bo_o
);
    assign d_o  = a_i ^ b_i ^ bi_i;
    assign bo_o = (~a_i & b_i) | (~(a_i ^ b_i) & bi_i);
endmodule

module st_serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ov
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   r_sh_q, r_sh_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bo_q, bo_d;
    logic               ov_q, ov_d;

    logic               cell_a, cell_b, cell_bi, cell_d, cell_bo;
    logic               last_bit;

    // The shared cell always looks at the current operand LSBs and the
    // carried borrow; its outputs are only used while running.
    assign cell_a  = a_sh_q[0];
    assign cell_b  = b_sh_q[0];
    assign cell_bi = borrow_q;

    st_fs_cell u_cell (
        .a_i  (cell_a),
        .b_i  (cell_b),
        .bi_i (cell_bi),
        .d_o  (cell_d),
        .bo_o (cell_bo)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        bo_d     = bo_q;
        ov_d     = ov_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                end
            end

            S_RUN: begin
                // Result bits enter at the MSB so that after WIDTH steps
                // bit 0 has drifted down to position 0.
                r_sh_d            = r_sh_q >> 1;
                r_sh_d[WIDTH-1]   = cell_d;
                borrow_d          = cell_bo;
                a_sh_d            = a_sh_q >> 1;
                b_sh_d            = b_sh_q >> 1;
                cnt_d             = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = S_DONE;
                    d_d     = r_sh_d;
                    bo_d    = cell_bo;
                    // On the last step the cell inputs are the captured MSBs.
                    ov_d    = (cell_a != cell_b) && (cell_d != cell_a);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            bo_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            bo_q     <= bo_d;
            ov_q     <= ov_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign d    = d_q;
    assign bo   = bo_q;
    assign ov   = ov_q;

endmodule

// File: tb/tb_st_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_st_serial_sub
//
// Directed bench for st_serial_sub (WIDTH=8). Each accepted request pushes its
// arithmetically computed result onto a scoreboard queue; the entry is popped
// and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_st_serial_sub;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;

    int   checks;
    int   failures;
    exp_t sb[$];

    st_serial_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bo    (bo),
        .ov    (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width subtraction; the extra top bit is the borrow.
    function automatic exp_t model(input logic [WIDTH-1:0] ma,
                                   input logic [WIDTH-1:0] mb,
                                   input logic             mbin);
        exp_t           e;
        logic [WIDTH:0] full;
        full = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mbin};
        e.d  = full[WIDTH-1:0];
        e.bo = full[WIDTH];
        e.ov = (ma[WIDTH-1] != mb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single cycle; returns at the negedge
    // following the accepting edge, with the inputs scrambled.
    task automatic applyStimulus(input logic [WIDTH-1:0] sa,
                                 input logic [WIDTH-1:0] sb_in,
                                 input logic             sbin);
        @(negedge clk);
        a     = sa;
        b     = sb_in;
        bin   = sbin;
        start = 1'b1;
        sb.push_back(model(sa, sb_in, sbin));
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        bin   = 1'($urandom);
    endtask

    // Waits (bounded) for done, counting busy cycles seen on the way, then
    // compares the result against the scoreboard head.
    task automatic await_done(input string tag, input int exp_busy);
        int   busy_cnt;
        bit   seen;
        exp_t e;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < WIDTH + 6; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_entry"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (seen) begin
                checkOutput({tag, "_busy_with_done"}, 32'(busy), 32'd0);
                checkOutput({tag, "_d"}, 32'(d), 32'(e.d));
                checkOutput({tag, "_bo"}, 32'(bo), 32'(e.bo));
                checkOutput({tag, "_ov"}, 32'(ov), 32'(e.ov));
                @(negedge clk);
                checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
                checkOutput({tag, "_d_hold"}, 32'(d), 32'(e.d));
            end
        end
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        checkOutput({tag, "_no_done"}, 32'(n), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        bin      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_d", 32'(d), 32'd0);
        checkOutput("rst_bo", 32'(bo), 32'd0);
        checkOutput("rst_ov", 32'(ov), 32'd0);

        // Known cases, with test-plan constants checked directly as well.
        applyStimulus(8'h5A, 8'h23, 1'b0);
        await_done("basic", WIDTH);
        checkOutput("basic_const_d", 32'(d), 32'h37);

        applyStimulus(8'h00, 8'h01, 1'b0);
        await_done("underflow", WIDTH);
        checkOutput("underflow_const_bo", 32'(bo), 32'd1);

        applyStimulus(8'h80, 8'h01, 1'b0);
        await_done("ovf_neg", WIDTH);
        checkOutput("ovf_neg_const_ov", 32'(ov), 32'd1);

        applyStimulus(8'h7F, 8'hFF, 1'b0);
        await_done("ovf_pos", WIDTH);
        checkOutput("ovf_pos_const_d", 32'(d), 32'h80);

        applyStimulus(8'h10, 8'h0F, 1'b1);
        await_done("bin_zero", WIDTH);

        applyStimulus(8'h00, 8'h00, 1'b1);
        await_done("bin_wrap", WIDTH);
        checkOutput("bin_wrap_const_d", 32'(d), 32'hFF);

        // A start during RUN (sampled at the third bit edge) must be ignored.
        applyStimulus(8'h33, 8'h11, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'h01;
        bin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        await_done("ignore", WIDTH - 3);
        expect_no_done("ignore", WIDTH + 4);
        checkOutput("ignore_sb_empty", 32'(sb.size()), 32'd0);

        // Reset sampled at the fourth bit edge abandons the operation.
        applyStimulus(8'h44, 8'h22, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_d", 32'(d), 32'd0);
        checkOutput("midrst_bo", 32'(bo), 32'd0);
        checkOutput("midrst_ov", 32'(ov), 32'd0);
        if (sb.size() > 0) void'(sb.pop_front());
        expect_no_done("midrst", WIDTH + 4);

        applyStimulus(8'hC3, 8'h3C, 1'b0);
        await_done("fresh", WIDTH);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            await_done("rand", WIDTH);
        end

        checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
